// File: rtl/scope_capture_if.sv
// scope_capture_if: sample stream into scope_capture and line-buffer write port out of it
//   sample_valid, sample_in : ADC sample stream (driven by the source)
//   wr_en, wr_addr, wr_data : back line buffer write port (driven by scope_capture)
interface scope_capture_if #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 10
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [15:0]         wr_data;
    modport master (output sample_valid, sample_in, input wr_en, wr_addr, wr_data);
    modport slave (input sample_valid, sample_in, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/scope_capture.sv
// scope_capture: decimate ADC samples, trigger, write one row-mapped record per screen, swap on vblank
//   clk, reset        : clock, asynchronous active-high reset
//   run, single       : continuous re-arm / one-shot arm
//   auto_en           : forced trigger after AUTO_TIMEOUT decimated samples
//   trig_rising       : 1 rising edge, 0 falling edge
//   trig_level, decim : trigger threshold, keep 1 of decim+1 valid samples
//   vblank            : vertical blank level
//   bus               : sample stream in, buffer write port out
//   swap, busy        : buffer swap pulse, record in progress
//   auto_trig         : last record was force-triggered
module scope_capture #(
    parameter int SAMPLE_W     = 12,
    parameter int DEPTH        = 640,
    parameter int ADDR_W       = 10,
    parameter int ROW_BASE     = 40,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                single,
    input  logic                auto_en,
    input  logic                trig_rising,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [7:0]          decim,
    input  logic                vblank,
    scope_capture_if.slave      bus,
    output logic                swap,
    output logic                busy,
    output logic                auto_trig
);
    localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, WAIT_VB} state_t;

    state_t              state, state_n;
    logic [7:0]          decim_l, dcnt;
    logic [SAMPLE_W-1:0] level_l, prev, cur;
    logic                rising_l, auto_en_l, have_prev, vb_prev;
    logic [TO_W-1:0]     acnt;
    logic [ADDR_W-1:0]   addr;
    logic [9:0]          row;
    logic                dstb, hit, timeout, arm, fire, wr_n, swap_n;

    assign cur     = bus.sample_in;
    assign dstb    = bus.sample_valid && dcnt == decim_l;
    // the first kept sample after arming only seeds prev
    assign hit     = have_prev && (rising_l ? (prev < level_l && cur >= level_l)
                                            : (prev > level_l && cur <= level_l));
    assign timeout = auto_en_l && acnt == TO_W'(AUTO_TIMEOUT - 1);
    assign row     = 10'(ROW_BASE) + {2'b0, 8'd255 - cur[SAMPLE_W-1 -: 8]};
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        arm     = 1'b0;
        fire    = 1'b0;
        wr_n    = 1'b0;
        swap_n  = 1'b0;
        case (state)
            IDLE: begin
                arm     = single || run;
                state_n = arm ? ARMED : IDLE;
            end
            ARMED: begin
                fire    = dstb && (hit || timeout);
                wr_n    = fire;
                state_n = fire ? CAPTURE : ARMED;
            end
            CAPTURE: begin
                wr_n    = dstb;
                state_n = dstb && addr == ADDR_W'(DEPTH - 1) ? WAIT_VB : CAPTURE;
            end
            WAIT_VB: begin
                swap_n  = vblank && !vb_prev;
                arm     = swap_n && run;
                state_n = swap_n ? (run ? ARMED : IDLE) : WAIT_VB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            swap        <= 1'b0;
            auto_trig   <= 1'b0;
            decim_l     <= '0;
            level_l     <= '0;
            rising_l    <= 1'b0;
            auto_en_l   <= 1'b0;
            dcnt        <= '0;
            acnt        <= '0;
            prev        <= '0;
            have_prev   <= 1'b0;
            addr        <= '0;
            vb_prev     <= 1'b0;
        end else begin
            vb_prev   <= vblank;
            bus.wr_en <= wr_n;
            swap      <= swap_n;
            if (wr_n) begin
                bus.wr_addr <= fire ? '0 : addr;
                bus.wr_data <= {6'b0, row};
            end
            // addr holds the column of the next capture write
            if (fire) addr <= ADDR_W'(1);
            else if (state == CAPTURE && dstb) addr <= addr + ADDR_W'(1);
            if (arm) begin
                decim_l   <= decim;
                level_l   <= trig_level;
                rising_l  <= trig_rising;
                auto_en_l <= auto_en;
                dcnt      <= '0;
                acnt      <= '0;
                have_prev <= 1'b0;
            end else begin
                if (bus.sample_valid) dcnt <= dstb ? 8'd0 : dcnt + 8'd1;
                if (state == ARMED && dstb) begin
                    prev      <= cur;
                    have_prev <= 1'b1;
                    acnt      <= acnt + TO_W'(1);
                end
            end
            // a real trigger wins over a simultaneous timeout
            if (state == IDLE && arm) auto_trig <= 1'b0;
            else if (fire) auto_trig <= !hit;
        end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed stimulus with a record-level reference model for scope_capture
module tb_scope_capture;
    localparam int DEPTH = 640;
    localparam int AUTO_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, single = 1'b0, auto_en = 1'b0, trig_rising = 1'b0, vblank = 1'b0;
    logic [11:0] trig_level = '0;
    logic [7:0]  decim = '0;
    logic       swap, busy, auto_trig;

    scope_capture_if #(.SAMPLE_W(12), .ADDR_W(10)) bus ();

    scope_capture dut (
        .clk(clk), .reset(reset), .run(run), .single(single), .auto_en(auto_en),
        .trig_rising(trig_rising), .trig_level(trig_level), .decim(decim),
        .vblank(vblank), .bus(bus), .swap(swap), .busy(busy), .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, nswap = 0, step = 0;
    bit gap = 0;
    int wlog_addr[$], wlog_data[$], wlog_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int row_of(input int s);
        return 40 + 255 - (s >> 4);
    endfunction

    // reference model: one record = kept samples counted from arming, trigger
    // located among them, then DEPTH consecutive columns, then a vblank edge
    bit mbusy = 0, tgd = 0, mr = 0, mauto = 0, vbp = 0;
    int md = 0, lvl = 0, nvalid = 0, nk = 0, nwr = 0, prevs = 0;
    bit e_wr = 0, e_swap = 0, e_auto = 0;
    int e_addr = 0, e_data = 0;

    task automatic arm_model();
        mbusy = 1; tgd = 0; md = decim; lvl = trig_level; mr = trig_rising; mauto = auto_en;
        nvalid = 0; nk = 0; nwr = 0;
    endtask

    always @(posedge clk) begin
        bit kept, real_t, forced;
        int s;
        cyc++;
        s = bus.sample_in;
        e_wr = 0;
        e_swap = 0;
        if (reset) begin
            mbusy = 0; e_auto = 0; vbp = 0;
        end else begin
            kept = 0;
            if (mbusy && bus.sample_valid) begin
                kept = (nvalid % (md + 1)) == md;
                nvalid++;
            end
            if (!mbusy) begin
                if (run || single) begin arm_model(); e_auto = 0; end
            end else if (nwr == DEPTH) begin
                if (vblank && !vbp) begin
                    e_swap = 1;
                    mbusy = run;
                    if (run) arm_model();
                end
            end else if (kept && tgd) begin
                e_wr = 1; e_addr = nwr; e_data = row_of(s); nwr++;
            end else if (kept) begin
                nk++;
                real_t = nk > 1 && (mr ? (prevs < lvl && s >= lvl) : (prevs > lvl && s <= lvl));
                forced = mauto && nk == AUTO_TIMEOUT;
                if (real_t || forced) begin
                    tgd = 1; e_auto = !real_t; e_wr = 1; e_addr = 0; e_data = row_of(s); nwr = 1;
                end
                prevs = s;
            end
            vbp = vblank;
        end
    end

    always @(negedge clk) begin
        chk("wr_en", bus.wr_en, reset ? 0 : e_wr);
        chk("swap", swap, reset ? 0 : e_swap);
        chk("busy", busy, reset ? 0 : mbusy);
        chk("auto_trig", auto_trig, reset ? 0 : e_auto);
        if (!reset && e_wr) begin
            chk("wr_addr", bus.wr_addr, e_addr);
            chk("wr_data", bus.wr_data, e_data);
        end
        if (bus.wr_en) begin
            wlog_addr.push_back(bus.wr_addr);
            wlog_data.push_back(bus.wr_data);
            wlog_cyc.push_back(cyc);
        end
        if (swap) nswap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        tick();
        bus.sample_in = 12'(bus.sample_in + step);
        if (gap) bus.sample_valid = (cyc % 3) != 0;
    endtask

    task automatic clear();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
    endtask

    task automatic wait_writes(input int n, input int bound, input string name);
        int i = 0;
        while (wlog_addr.size() < n && i < bound) begin adv(); i++; end
        chk(name, wlog_addr.size() >= n, 1);
    endtask

    task automatic check_seq(input string name);
        int bad = 0;
        foreach (wlog_addr[i]) if (wlog_addr[i] != i) bad++;
        chk(name, bad, 0);
        chk({name, "_count"}, wlog_addr.size(), DEPTH);
    endtask

    task automatic vb_edge();
        vblank = 0;
        repeat (10) adv();
        clear();
        vblank = 1;
        repeat (2) adv();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t_hit, t_arm, n0, bad;
        bus.sample_valid = 1'b0;
        bus.sample_in = '0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_wr_addr", bus.wr_addr, 0);
        chk("reset_wr_data", bus.wr_data, 0);
        chk("reset_swap", swap, 0);
        chk("reset_auto", auto_trig, 0);
        reset = 0;
        tick();
        // rising trigger, continuous mode, vblank already high at record end
        trig_level = 12'd2048; trig_rising = 1; vblank = 1; step = 16;
        bus.sample_valid = 1; bus.sample_in = 0;
        clear();
        run = 1;
        t_hit = -1;
        for (int i = 0; i < 3000 && wlog_addr.size() < DEPTH; i++) begin
            adv();
            if (t_hit < 0 && bus.sample_in == 12'd2048) t_hit = cyc;
        end
        chk("rise_first_addr", wlog_addr[0], 0);
        chk("rise_first_data", wlog_data[0], 167);
        chk("rise_latency", wlog_cyc[0], t_hit + 1);
        chk("rise_last_addr", wlog_addr[DEPTH-1], 639);
        check_seq("rise_seq");
        repeat (5) adv();
        chk("swap_held_vblank", nswap, 0);
        vb_edge();
        chk("swap_once", nswap, 1);
        chk("run_rearm_busy", busy, 1);
        // run dropped while armed: record still completes, then idle
        run = 0;
        wait_writes(DEPTH, 4000, "rundrop_done");
        check_seq("rundrop_seq");
        vb_edge();
        chk("rundrop_swap", nswap, 2);
        chk("rundrop_idle", busy, 0);
        // falling trigger, single shot
        trig_rising = 0; trig_level = 12'd1000; step = 0; bus.sample_in = 0;
        single = 1; adv(); single = 0;
        for (int i = 1; i < 512; i++) begin bus.sample_in = 12'(8 * i); tick(); end
        chk("fall_no_rise_trig", wlog_addr.size(), 0);
        bus.sample_in = 12'd4095;
        repeat (4) tick();
        bus.sample_in = 0;
        tick();
        single = 1; tick(); single = 0;
        gap = 1;
        wait_writes(DEPTH, 3000, "fall_done");
        gap = 0; bus.sample_valid = 1;
        chk("fall_first_addr", wlog_addr[0], 0);
        chk("fall_first_data", wlog_data[0], 295);
        check_seq("fall_seq");
        vb_edge();
        chk("single_idle", busy, 0);
        chk("fall_swap", nswap, 3);
        // decimation by 4
        decim = 3; trig_rising = 1; trig_level = 12'd2048; step = 1; bus.sample_in = 0;
        single = 1; adv(); single = 0;
        wait_writes(DEPTH, 6000, "decim_done");
        chk("decim_first_data", wlog_data[0], 167);
        chk("decim_data_64", wlog_data[64], 151);
        bad = 0;
        for (int i = 1; i < wlog_cyc.size(); i++) if (wlog_cyc[i] - wlog_cyc[i-1] != 4) bad++;
        chk("decim_spacing", bad, 0);
        check_seq("decim_seq");
        vb_edge();
        chk("decim_idle", busy, 0);
        decim = 0;
        // auto trigger on dstb 1024
        auto_en = 1; step = 0; bus.sample_in = 12'd100;
        single = 1; t_arm = cyc; adv(); single = 0;
        wait_writes(DEPTH, 2000, "auto_done");
        chk("auto_latency", wlog_cyc[0], t_arm + 1025);
        chk("auto_first_data", wlog_data[0], 289);
        chk("auto_flag", auto_trig, 1);
        vb_edge();
        chk("auto_idle", busy, 0);
        // real trigger coinciding with timeout
        single = 1; adv(); single = 0;
        repeat (1023) adv();
        bus.sample_in = 12'd3000;
        wait_writes(DEPTH, 2000, "coincide_done");
        chk("coincide_data", wlog_data[0], 108);
        chk("coincide_flag", auto_trig, 0);
        vb_edge();
        // no auto trigger: never writes
        auto_en = 0; bus.sample_in = 12'd100;
        single = 1; adv(); single = 0;
        repeat (1100) adv();
        chk("noauto_writes", wlog_addr.size(), 0);
        chk("noauto_busy", busy, 1);
        reset = 1;
        #1;
        chk("rst_armed_busy", busy, 0);
        repeat (3) tick();
        reset = 0;
        // reset in the middle of a capture
        trig_level = 12'd2048; trig_rising = 1; step = 16; bus.sample_in = 0; vblank = 0;
        clear();
        run = 1;
        wait_writes(100, 3000, "rst_pre_done");
        n0 = nswap;
        reset = 1;
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_swap", swap, 0);
        chk("rst_busy", busy, 0);
        vblank = 1;
        repeat (3) tick();
        reset = 0;
        clear();
        bus.sample_in = 0;
        wait_writes(1, 1000, "rst_restart");
        chk("rst_restart_addr", wlog_addr[0], 0);
        chk("rst_restart_data", wlog_data[0], 167);
        run = 0;
        wait_writes(DEPTH, 2000, "rst_rec_done");
        check_seq("rst_rec_seq");
        chk("rst_no_swap", nswap, n0);
        vb_edge();
        chk("rst_final_swap", nswap, n0 + 1);
        chk("rst_final_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
